// File: rtl/mips_cpu_bus_master.sv
// ---------------------------------------------------------------------------
// mips_cpu_bus_master
//
// Bus initiator between the CPU load/store unit and an Avalon-style memory
// bus. Takes one byte/half/word request at a time, turns the byte address
// into a word-aligned bus address plus byteenable, lane-shifts store data,
// holds the bus request through waitrequest, captures read data one cycle
// after the read is accepted and returns a sign/zero-extended load result.
//
// Ports
//   clk, reset_n      clock (rising edge) / asynchronous active-low reset
//   req_valid/ready   CPU request handshake (ready only while idle)
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 reserved (misaligned)
//   req_signed        loads: 1 = sign-extend, 0 = zero-extend
//   req_addr          byte address
//   req_wdata         right-justified store data
//   resp_valid        one-cycle completion pulse
//   resp_err          misaligned request, no bus access made
//   resp_rdata        load result (0 for stores and errors), held until next
//   address           word-aligned bus address
//   read / write      bus strobes (never both high)
//   byteenable        active byte lanes
//   writedata         lane-shifted store data, unused lanes zero
//   waitrequest       slave stall
//   readdata          slave data, valid the cycle after read acceptance
// ---------------------------------------------------------------------------
module mips_cpu_bus_master #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // CPU side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    // Bus side
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    output logic [3:0]            byteenable,
    output logic [31:0]           writedata,
    input  logic                  waitrequest,
    input  logic [31:0]           readdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RDATA,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_offset;
    logic [1:0]              r_size;
    logic                    r_signed;
    logic                    r_req_ready;
    logic                    r_resp_valid;
    logic                    r_resp_err;
    logic [31:0]             r_resp_rdata;
    logic [ADDR_WIDTH-1:0]   r_address;
    logic                    r_read;
    logic                    r_write;
    logic [3:0]              r_byteenable;
    logic [31:0]             r_writedata;

    logic [1:0]              w_offset;
    logic                    w_misaligned;
    logic [3:0]              w_byteenable;
    logic [31:0]             w_wdata_shifted;
    logic [31:0]             w_writedata;
    logic [31:0]             w_rdata_shifted;
    logic [31:0]             w_load_data;

    assign w_offset = req_addr[1:0];

    // Request decode: alignment, lane mask and lane-shifted store data.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_misaligned    = 1'b0;
        w_byteenable    = 4'b0000;
        w_wdata_shifted = req_wdata << {w_offset, 3'b000};
        w_writedata     = 32'h0;
        unique case (req_size)
            2'b00: w_byteenable = 4'b0001 << w_offset;
            2'b01: begin
                w_misaligned = w_offset[0];
                w_byteenable = w_offset[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_misaligned = (w_offset != 2'b00);
                w_byteenable = 4'b1111;
            end
            default: w_misaligned = 1'b1;
        endcase
        for (int i = 0; i < 4; i++) begin
            w_writedata[8*i +: 8] = w_byteenable[i] ? w_wdata_shifted[8*i +: 8] : 8'h00;
        end
    end

    // Load result: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        w_rdata_shifted = readdata >> {r_offset, 3'b000};
        w_load_data     = readdata;
        unique case (r_size)
            2'b00:   w_load_data = {{24{r_signed & w_rdata_shifted[7]}},  w_rdata_shifted[7:0]};
            2'b01:   w_load_data = {{16{r_signed & w_rdata_shifted[15]}}, w_rdata_shifted[15:0]};
            default: w_load_data = readdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_offset     <= 2'b00;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_byteenable <= 4'b0000;
            r_writedata  <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_offset    <= w_offset;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_req_ready <= 1'b0;
                        if (w_misaligned) begin
                            // Rejected without touching the bus.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end else begin
                            r_address    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            r_byteenable <= w_byteenable;
                            r_writedata  <= w_writedata;
                            if (req_write) begin
                                r_write <= 1'b1;
                                r_state <= S_WRITE;
                            end else begin
                                r_read  <= 1'b1;
                                r_state <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (!waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    // Fixed one-cycle read latency: readdata is valid now.
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= w_load_data;
                end
                S_WRITE: begin
                    if (!waitrequest) begin
                        r_write      <= 1'b0;
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'h0;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_read      <= 1'b0;
                    r_write     <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_write;
    assign byteenable = r_byteenable;
    assign writedata  = r_writedata;

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_bus_master
//
// Self-checking bench. Acts as both CPU and bus slave. Expected values come
// from a byte-addressed reference memory (stores write bytes addr..addr+n-1,
// loads assemble and extend them) and from the cycle-by-cycle latency rules.
// The slave memory is word-based and is only updated through the DUT's own
// bus writes, so lane errors surface on later loads.
// ---------------------------------------------------------------------------
module tb_mips_cpu_bus_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    int n_checks = 0;
    int n_errors = 0;

    // Reference (byte view) and slave (word view) memories.
    logic [7:0]  ref_bytes [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];

    // Fields driven while a chained request is waiting for IDLE.
    logic        nxt_write;
    logic [1:0]  nxt_size;
    logic        nxt_signed;
    logic [31:0] nxt_addr;
    logic [31:0] nxt_wdata;

    mips_cpu_bus_master #(.ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, act, exp);
        end
    endtask

    // Background contents for never-written locations.
    function automatic logic [31:0] seed_word(input logic [31:0] waddr);
        return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (ref_bytes.exists(a)) return ref_bytes[a];
        w = seed_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic logic [31:0] slave_word(input logic [31:0] waddr);
        if (slave_mem.exists(waddr)) return slave_mem[waddr];
        return seed_word(waddr);
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        slave_mem[a] = v;
        for (int j = 0; j < 4; j++) ref_bytes[a + j] = v[8*j +: 8];
    endtask

    // Request inputs while the block is busy: either the chained next
    // request or random junk that must be ignored.
    task automatic drive_busy(input bit chain);
        if (chain) begin
            req_valid  = 1'b1;
            req_write  = nxt_write;
            req_size   = nxt_size;
            req_signed = nxt_signed;
            req_addr   = nxt_addr;
            req_wdata  = nxt_wdata;
        end else begin
            req_valid  = 1'($urandom_range(0, 1));
            req_write  = 1'($urandom_range(0, 1));
            req_size   = 2'($urandom_range(0, 3));
            req_signed = 1'($urandom_range(0, 1));
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
    endtask

    // One complete transaction; entered and left at a falling edge in IDLE.
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int n_wait, input bit chain);
        int          n;
        int          o;
        bit          mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic [31:0] acc_addr;
        logic [31:0] merged;
        logic [31:0] be_i;

        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        o   = int'(addr[1:0]);
        mis = (sz == 2'b11) || ((o % n) != 0);
        be_i   = ((32'd1 << n) - 32'd1) << o;
        exp_be = be_i[3:0];
        exp_wd = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (exp_be[i]) exp_wd[8*i +: 8] = wd[8*(i - o) +: 8];
        end
        exp_rd   = 32'h0;
        acc_addr = 32'h0;

        check("req_ready_idle", {31'h0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_write   = wr;
        req_size    = sz;
        req_signed  = sg;
        req_addr    = addr;
        req_wdata   = wd;
        waitrequest = 1'($urandom_range(0, 1));
        @(negedge clk);
        drive_busy(chain);

        if (!mis) begin
            for (int k = 0; k <= n_wait; k++) begin
                check("bus_read",    {31'h0, read},  {31'h0, ~wr});
                check("bus_write",   {31'h0, write}, {31'h0, wr});
                check("bus_address", address, {addr[31:2], 2'b00});
                check("bus_be",      {28'h0, byteenable}, {28'h0, exp_be});
                if (wr) check("bus_wdata", writedata, exp_wd);
                check("busy_resp_valid", {31'h0, resp_valid}, 32'd0);
                check("busy_ready",      {31'h0, req_ready},  32'd0);
                waitrequest = (k < n_wait);
                if (k == n_wait) begin
                    acc_addr = address;
                    if (write) begin
                        merged = slave_word(acc_addr);
                        for (int i = 0; i < 4; i++)
                            if (byteenable[i]) merged[8*i +: 8] = writedata[8*i +: 8];
                        slave_mem[acc_addr] = merged;
                    end
                end
                @(negedge clk);
                drive_busy(chain);
            end
            if (wr) begin
                for (int j = 0; j < n; j++) ref_bytes[addr + j] = wd[8*j +: 8];
            end else begin
                check("rdata_read_low",  {31'h0, read},       32'd0);
                check("rdata_resp_low",  {31'h0, resp_valid}, 32'd0);
                readdata    = slave_word(acc_addr);
                waitrequest = 1'($urandom_range(0, 1));
                for (int j = 0; j < n; j++) exp_rd[8*j +: 8] = ref_byte(addr + j);
                if (sg && n < 4 && exp_rd[8*n - 1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*n));
                @(negedge clk);
                drive_busy(chain);
                readdata = $urandom;
            end
        end

        // Response cycle.
        check("resp_valid", {31'h0, resp_valid}, 32'd1);
        check("resp_err",   {31'h0, resp_err},   {31'h0, mis});
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_bus_idle", {30'h0, read, write}, 32'd0);
        if (!chain) req_valid = 1'b0;
        @(negedge clk);
        check("resp_pulse_end", {31'h0, resp_valid}, 32'd0);
        check("resp_err_hold",  {31'h0, resp_err},   {31'h0, mis});
        check("resp_rdata_hold", resp_rdata, exp_rd);
    endtask

    // read and write must never be high together.
    always @(negedge clk) begin
        if (reset_n && (read || write)) check("strobe_overlap", {31'h0, read & write}, 32'd0);
    end

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        waitrequest = 1'b0;
        readdata    = 32'h0;
        nxt_write   = 1'b0;
        nxt_size    = 2'b00;
        nxt_signed  = 1'b0;
        nxt_addr    = 32'h0;
        nxt_wdata   = 32'h0;

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_read",       {31'h0, read},       32'd0);
        check("rst_write",      {31'h0, write},      32'd0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'h0, resp_err},   32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_address",    address,             32'd0);
        check("rst_be",         {28'h0, byteenable}, 32'd0);
        check("rst_wdata",      writedata,           32'd0);
        check("rst_ready",      {31'h0, req_ready},  32'd1);

        // Word load.
        set_word(32'h1004, 32'hDEAD_BEEF);
        run_txn(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 0, 1'b0);
        check("tp_word_load", resp_rdata, 32'hDEAD_BEEF);

        // Byte load, signed then unsigned, from lane 3.
        set_word(32'h1004, 32'h80FF_0000);
        run_txn(1'b0, 2'b00, 1'b1, 32'h1007, 32'h0, 0, 1'b0);
        check("tp_sbyte", resp_rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 2'b00, 1'b0, 32'h1007, 32'h0, 0, 1'b0);
        check("tp_ubyte", resp_rdata, 32'h0000_0080);

        // Half store at upper half with three stall cycles.
        run_txn(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_ABCD, 3, 1'b0);
        check("tp_half_store_mem", slave_word(32'h2000) & 32'hFFFF_0000, 32'hABCD_0000);

        // Misaligned word load.
        run_txn(1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 0, 1'b0);
        check("tp_misaligned_err", {31'h0, resp_err}, 32'd1);

        // Reset asserted mid-read while stalled.
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_size    = 2'b10;
        req_signed  = 1'b0;
        req_addr    = 32'h1000;
        waitrequest = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_read_high", {31'h0, read}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_read_drop", {31'h0, read},       32'd0);
        check("rst_mid_no_resp",   {31'h0, resp_valid}, 32'd0);
        @(negedge clk);
        reset_n     = 1'b1;
        waitrequest = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_after_no_resp", {31'h0, resp_valid}, 32'd0);
            check("rst_after_no_read", {31'h0, read},       32'd0);
        end
        run_txn(1'b0, 2'b01, 1'b1, 32'h1006, 32'h0, 1, 1'b0);

        // Back-to-back store then load to 0x40 with req_valid held high.
        nxt_write  = 1'b0;
        nxt_size   = 2'b10;
        nxt_signed = 1'b0;
        nxt_addr   = 32'h40;
        nxt_wdata  = 32'h0;
        run_txn(1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 0, 1'b1);
        run_txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 1'b0);
        check("tp_b2b_load", resp_rdata, 32'h1234_5678);

        // Randomized traffic in a small window so loads hit earlier stores.
        for (int t = 0; t < 250; t++) begin
            run_txn(1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    32'h100 + 32'($urandom_range(0, 31)),
                    $urandom,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                    1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
